// File: rtl/det5_stream_loader.sv
// det5_stream_loader
// Sequential front end for the combinational 5x5 determinant unit.
// It collects 25 signed 8-bit elements in row-major order over a valid/ready
// stream and drives them onto a 200-bit matrix bus. It waits SETTLE_CYCLES
// edges for the determinant path to settle, then captures det/ovf and holds
// them under a valid/ready output handshake.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   clear      synchronous abort back to LOAD (matrix zeroed, det/ovf kept)
//   in_valid / in_ready / in_data   element input stream
//   matrix     element k (k = 5*row + col) at matrix[199-8k -: 8]
//   det_in / ovf_in                 result from the determinant unit
//   out_valid / out_ready / det / ovf   captured result stream
//   busy       high while settling or holding a result
//   count      elements accepted in the current load, 0..25
module det5_stream_loader #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic [199:0] matrix,
  input  logic [7:0]   det_in,
  input  logic         ovf_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   det,
  output logic         ovf,
  output logic         busy,
  output logic [4:0]   count
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX    = 5'd24;
  // The counter is loaded on the 25th transfer edge and the capture happens
  // on the edge where it reads zero, giving exactly SETTLE_CYCLES edges.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] det_q, det_d;
  logic       ovf_q, ovf_d;
  logic       xfer;

  // in_ready is decoded from state, so a transfer is simply valid in LOAD.
  assign xfer = (state_q == ST_LOAD) && in_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:   if (in_valid && count_q == LAST_IDX) state_d = ST_SETTLE;
        ST_SETTLE: if (settle_q == 4'd0)                state_d = ST_DONE;
        ST_DONE:   if (out_ready)                       state_d = ST_LOAD;
        default:                                        state_d = ST_LOAD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from state only (no valid->ready paths)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_LOAD:   in_ready = 1'b1;
      ST_SETTLE: busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and result capture
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    settle_d = settle_q;
    det_d    = det_q;
    ovf_d    = ovf_q;
    if (clear) begin
      // det/ovf deliberately survive an abort
      count_d  = 5'd0;
      settle_d = 4'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            count_d = count_q + 5'd1;
            if (count_q == LAST_IDX) settle_d = SETTLE_INIT;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 4'd0) begin
            det_d = det_in;
            ovf_d = ovf_in;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) count_d = 5'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 5'd0;
      settle_q <= 4'd0;
      det_q    <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      settle_q <= settle_d;
      det_q    <= det_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Matrix slots: each slot only writes when count points at it, so the bus
  // is frozen outside LOAD and a new load overwrites old contents in place.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 25; gi++) begin : g_slot
    logic [7:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (clear) begin
        slot_d = 8'd0;
      end else if (xfer && count_q == 5'(gi)) begin
        slot_d = in_data;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_q <= 8'd0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign matrix[199-8*gi -: 8] = slot_q;
  end

  assign count = count_q;
  assign det   = det_q;
  assign ovf   = ovf_q;

endmodule
